// File: rtl/score_controller_if.sv
// Move handshake between the board engine (master) and the score controller (slave).
interface score_controller_if;
    logic        move_valid;
    logic [15:0] move_merge;
    logic        move_ready;

    modport master (
        output move_valid,
        output move_merge,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_merge,
        output move_ready
    );
endinterface

// File: rtl/score_controller.sv
// Sequences one move at a time into the 2048 scorer, waits out its pipeline,
// then samples the settled BCD score and tracks the session best.
module score_controller #(
    parameter int PIPE_LAT   = 5,
    parameter int CLR_CYCLES = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    score_controller_if.slave    mv,
    input  logic                 new_game,
    output logic [15:0]          score_en,
    output logic                 scorer_rst,
    input  logic [19:0]          score_bcd,
    output logic [19:0]          last_bcd,
    output logic [19:0]          best_bcd,
    output logic                 score_valid,
    output logic                 new_best,
    output logic                 busy
);

    localparam int CNT_MAX = (CLR_CYCLES > PIPE_LAT) ? CLR_CYCLES : PIPE_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COMPARE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [15:0]        score_en_r;
    logic [15:0]        score_en_s;
    logic [19:0]        last_bcd_r;
    logic [19:0]        last_bcd_s;
    logic [19:0]        best_bcd_r;
    logic [19:0]        best_bcd_s;
    logic               new_best_r;
    logic               new_best_s;
    logic               score_valid_r;
    logic               score_valid_s;
    logic               scorer_rst_r;
    logic               move_ready_r;
    logic               busy_r;
    logic               accept_s;

    // move_ready_r is high exactly while the state is IDLE, so it alone qualifies acceptance
    assign accept_s = mv.move_valid & move_ready_r;

    // Next-state and next-output decode; new_game overrides everything
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        score_en_s    = 16'h0000;
        last_bcd_s    = last_bcd_r;
        best_bcd_s    = best_bcd_r;
        new_best_s    = new_best_r;
        score_valid_s = 1'b0;
        if (new_game) begin
            state_s    = ST_CLEAR;
            cnt_s      = CNT_W'(CLR_CYCLES);
            last_bcd_s = 20'h00000;
            new_best_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    // A zero mask is consumed in place with no scorer activity
                    if (accept_s && (mv.move_merge != 16'h0000)) begin
                        state_s    = ST_ISSUE;
                        score_en_s = mv.move_merge;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_s = ST_WAIT;
                    cnt_s   = CNT_W'(PIPE_LAT);
                end
                ST_WAIT: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_s = ST_COMPARE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    last_bcd_s    = score_bcd;
                    score_valid_s = 1'b1;
                    state_s       = ST_IDLE;
                    // Plain unsigned compare orders valid BCD by decimal magnitude
                    if (score_bcd > best_bcd_r) begin
                        best_bcd_s = score_bcd;
                        new_best_s = 1'b1;
                    end else begin
                        best_bcd_s = best_bcd_r;
                    end
                end
                default: begin
                    state_s = ST_CLEAR;
                    cnt_s   = CNT_W'(CLR_CYCLES);
                end
            endcase
        end
    end

    // State, counter and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_CLEAR;
            cnt_r         <= CNT_W'(CLR_CYCLES);
            score_en_r    <= 16'h0000;
            scorer_rst_r  <= 1'b0;
            move_ready_r  <= 1'b0;
            last_bcd_r    <= 20'h00000;
            best_bcd_r    <= 20'h00000;
            new_best_r    <= 1'b0;
            score_valid_r <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            score_en_r    <= score_en_s;
            scorer_rst_r  <= (state_s != ST_CLEAR);
            move_ready_r  <= (state_s == ST_IDLE);
            last_bcd_r    <= last_bcd_s;
            best_bcd_r    <= best_bcd_s;
            new_best_r    <= new_best_s;
            score_valid_r <= score_valid_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign mv.move_ready = move_ready_r;
    assign score_en      = score_en_r;
    assign scorer_rst    = scorer_rst_r;
    assign last_bcd      = last_bcd_r;
    assign best_bcd      = best_bcd_r;
    assign new_best      = new_best_r;
    assign score_valid   = score_valid_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: expected score updates are queued by the
// stimulus thread and checked by a monitor whenever score_valid is seen.
module tb_score_controller;

    localparam logic [19:0] STALE = 20'h00001;

    typedef struct {
        logic [19:0] last_v;
        logic [19:0] best_v;
        logic        nb_v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        new_game;
    logic [15:0] score_en;
    logic        scorer_rst;
    logic [19:0] score_bcd;
    logic [19:0] last_bcd;
    logic [19:0] best_bcd;
    logic        score_valid;
    logic        new_best;
    logic        busy;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    score_controller_if mv();

    score_controller #(.PIPE_LAT(5), .CLR_CYCLES(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .mv          (mv),
        .new_game    (new_game),
        .score_en    (score_en),
        .scorer_rst  (scorer_rst),
        .score_bcd   (score_bcd),
        .last_bcd    (last_bcd),
        .best_bcd    (best_bcd),
        .score_valid (score_valid),
        .new_best    (new_best),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every score_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && score_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_score_valid: got last_bcd 0x%0h with no expected update at %0t",
                         last_bcd, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_last_bcd", {12'h000, last_bcd}, {12'h000, e.last_v});
                chk("sb_best_bcd", {12'h000, best_bcd}, {12'h000, e.best_v});
                chk("sb_new_best", {31'd0, new_best}, {31'd0, e.nb_v});
            end
        end
    end

    // Count consecutive cycles of scorer clear, starting at the current cycle
    task automatic wait_clear(output int lows, output logic leak);
        lows = 0;
        leak = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (scorer_rst) break;
            lows++;
            if ((score_en != 16'h0000) || mv.move_ready || score_valid) leak = 1'b1;
            step();
        end
    endtask

    task automatic do_move(input logic [15:0] mask, input logic [19:0] settle,
                           input logic [19:0] exp_last, input logic [19:0] exp_best,
                           input logic exp_nb);
        chk("ready_before_move", {31'd0, mv.move_ready}, 32'd1);
        mv.move_valid = 1'b1;
        mv.move_merge = mask;
        score_bcd     = STALE;
        step();                              // T+1
        mv.move_valid = 1'b0;
        mv.move_merge = 16'h0000;
        chk("score_en_issue", {16'h0000, score_en}, {16'h0000, mask});
        chk("ready_low_issue", {31'd0, mv.move_ready}, 32'd0);
        step();                              // T+2
        chk("score_en_cleared", {16'h0000, score_en}, 32'd0);
        chk("busy_wait", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) step(); // T+6
        exp_q.push_back('{exp_last, exp_best, exp_nb});
        step();                              // T+7: only cycle the settled score is shown
        score_bcd = settle;
        step();                              // T+8
        score_bcd = STALE;
        chk("score_valid_timing", {31'd0, score_valid}, 32'd1);
        chk("ready_after_move", {31'd0, mv.move_ready}, 32'd1);
        step();                              // T+9
        chk("score_valid_single", {31'd0, score_valid}, 32'd0);
    endtask

    initial begin
        int   lows;
        logic leak;

        rst           = 1'b0;
        new_game      = 1'b0;
        mv.move_valid = 1'b0;
        mv.move_merge = 16'h0000;
        score_bcd     = 20'h00000;

        // Reset values
        for (int i = 0; i < 3; i++) step();
        chk("rst_move_ready", {31'd0, mv.move_ready}, 32'd0);
        chk("rst_score_en", {16'h0000, score_en}, 32'd0);
        chk("rst_scorer_rst", {31'd0, scorer_rst}, 32'd0);
        chk("rst_score_valid", {31'd0, score_valid}, 32'd0);
        chk("rst_new_best", {31'd0, new_best}, 32'd0);
        chk("rst_last_bcd", {12'h000, last_bcd}, 32'd0);
        chk("rst_best_bcd", {12'h000, best_bcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // Reset release: six clear cycles, then ready
        rst = 1'b1;
        wait_clear(lows, leak);
        chk("release_clear_len", lows, 32'd6);
        chk("release_no_leak", {31'd0, leak}, 32'd0);
        chk("release_ready", {31'd0, mv.move_ready}, 32'd1);
        chk("release_busy", {31'd0, busy}, 32'd0);

        // Single move, first score of the session
        do_move(16'h0003, 20'h00012, 20'h00012, 20'h00012, 1'b1);

        // Zero mask: consumed with no scorer activity
        mv.move_valid = 1'b1;
        mv.move_merge = 16'h0000;
        step();
        mv.move_valid = 1'b0;
        chk("zero_ready_held", {31'd0, mv.move_ready}, 32'd1);
        chk("zero_score_en", {16'h0000, score_en}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 9; i++) step();
        chk("zero_last_kept", {12'h000, last_bcd}, 32'h00012);

        // Raise the best, then a lower score and an equal score
        do_move(16'h0110, 20'h00120, 20'h00120, 20'h00120, 1'b1);
        do_move(16'h0006, 20'h00108, 20'h00108, 20'h00120, 1'b1);
        do_move(16'h0001, 20'h00120, 20'h00120, 20'h00120, 1'b1);

        // Abort during WAIT
        mv.move_valid = 1'b1;
        mv.move_merge = 16'h0F00;
        score_bcd     = 20'h00999;
        step();
        mv.move_valid = 1'b0;
        mv.move_merge = 16'h0000;
        step();
        step();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("abort_last_cleared", {12'h000, last_bcd}, 32'd0);
        chk("abort_new_best_cleared", {31'd0, new_best}, 32'd0);
        chk("abort_best_kept", {12'h000, best_bcd}, 32'h00120);
        wait_clear(lows, leak);
        chk("abort_clear_len", lows, 32'd6);
        chk("abort_no_leak", {31'd0, leak}, 32'd0);
        chk("abort_ready", {31'd0, mv.move_ready}, 32'd1);

        // Lower first score of the new game does not set new_best
        do_move(16'h0001, 20'h00004, 20'h00004, 20'h00120, 1'b0);

        // Collision: new_game beats a simultaneous move
        new_game      = 1'b1;
        mv.move_valid = 1'b1;
        mv.move_merge = 16'h8000;
        step();
        new_game      = 1'b0;
        mv.move_valid = 1'b0;
        mv.move_merge = 16'h0000;
        chk("collide_ready_dropped", {31'd0, mv.move_ready}, 32'd0);
        chk("collide_no_score_en", {16'h0000, score_en}, 32'd0);
        chk("collide_busy", {31'd0, busy}, 32'd1);
        wait_clear(lows, leak);
        chk("collide_clear_len", lows, 32'd6);
        chk("collide_no_leak", {31'd0, leak}, 32'd0);
        chk("collide_best_kept", {12'h000, best_bcd}, 32'h00120);

        // Only rst clears best_bcd
        rst = 1'b0;
        step();
        step();
        chk("rst_clears_best", {12'h000, best_bcd}, 32'd0);
        chk("rst_scorer_clear", {31'd0, scorer_rst}, 32'd0);
        rst = 1'b1;
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_score_valid: got %0d unconsumed expectations, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/score_controller.md
# score_controller

Sequencer for the score accumulation pipeline of the 2048 game. It accepts one completed move at a time from the board engine and drives the per-cell merge mask into the scorer for exactly one cycle. It waits out the scorer's fixed pipeline latency, then samples the settled BCD score and maintains the session best score. It also owns the scorer's clear, pulsing it on power-up and on every new game, so the accumulator never carries across games.

## Interface
Parameters:
- PIPE_LAT, 5, cycles from the score_en cycle until the scorer's accumulated BCD score reflects it; legal range ≥1.
- CLR_CYCLES, 6, length of the scorer clear pulse; must be ≥ PIPE_LAT+1 to flush the pipeline.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- move_valid  in  1  board engine has a completed move.
- move_merge  in  16  per-cell merge flags for that move; bit i corresponds to cell i.
- move_ready  out  1  controller can accept a move.
- new_game  in  1  single-cycle request to start a new game.
- score_en  out  16  merge mask to the scorer's score_signal input.
- scorer_rst  out  1  active-low synchronous clear to the scorer; registered.
- score_bcd  in  20  scorer's current accumulated score, 5 BCD digits.
- last_bcd  out  20  score latched after the most recent move.
- best_bcd  out  20  highest last_bcd seen since rst.
- score_valid  out  1  one-cycle pulse: last_bcd and best_bcd were just updated.
- new_best  out  1  sticky flag: best_bcd was raised during the current game.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: CLEAR, IDLE, ISSUE, WAIT, COMPARE.
- Reset state is CLEAR with the clear counter loaded to CLR_CYCLES.
- CLEAR:
  - scorer_rst=0 and move_ready=0.
  - Counter decrements each cycle; the state goes to IDLE when the count reaches 0.
  - new_game during CLEAR reloads the counter.
- IDLE:
  - move_ready=1.
  - A move is accepted when move_valid&&move_ready.
  - If move_merge==0, the move is consumed, the state stays IDLE and nothing else happens.
  - If move_merge!=0, the mask is latched and the state goes to ISSUE.
- ISSUE: score_en equals the latched mask for this single cycle, then the state goes to WAIT with the wait counter set to PIPE_LAT.
- WAIT: counter decrements each cycle; the state goes to COMPARE after PIPE_LAT cycles.
- COMPARE:
  - Samples score_bcd into last_bcd.
  - If score_bcd > best_bcd, best_bcd is loaded and new_best is set. The comparison is a 20-bit unsigned compare, which equals decimal magnitude for valid BCD; equal scores leave best_bcd unchanged.
  - The state goes to IDLE and score_valid pulses.
- score_en=0 in every state other than ISSUE.
- new_game in any state:
  - Takes priority and aborts any in-flight move; score_valid is not issued for it.
  - The state goes to CLEAR with the counter reloaded to CLR_CYCLES.
  - last_bcd→0 and new_best→0; best_bcd is preserved.
- Simultaneous new_game and move_valid in IDLE: new_game wins and the move is not accepted (move_ready drops the next cycle).
- rst clears best_bcd; only rst does.

## Timing
- Reset values:
  - Data and handshake: move_ready=0, score_en=0, scorer_rst=0.
  - Score outputs: score_valid=0, new_best=0, last_bcd=0, best_bcd=0.
  - Status: busy=1.
- After rst deasserts: scorer_rst stays low for CLR_CYCLES cycles and move_ready rises the cycle after.
- Move accepted in cycle T, with nonzero mask:
  - score_en is valid in cycle T+1.
  - COMPARE samples score_bcd in cycle T+2+PIPE_LAT.
  - score_valid=1 together with the updated last_bcd, best_bcd and new_best in cycle T+3+PIPE_LAT.
  - move_ready=1 again in cycle T+3+PIPE_LAT.
- Throughput: one nonzero-mask move per PIPE_LAT+3 cycles; zero-mask moves can be accepted every cycle.
- new_game sampled in cycle N: scorer_rst=0 from N+1 through N+CLR_CYCLES, and move_ready=1 at N+CLR_CYCLES+1.

## Test plan
- Reset release: rst low 3 cycles, then high → scorer_rst low for exactly 6 cycles, move_ready rises on cycle 7, and all other outputs hold their reset values.
- Single move: mask 0x0003 accepted at T, model scorer presents 0x00012 from T+7 → score_en=0x0003 only at T+1, score_valid at T+8, last_bcd=best_bcd=0x00012, new_best=1.
- Zero mask: move_valid with 0x0000 → accepted, score_en stays 0, no score_valid, and move_ready stays high the next cycle.
- Lower score: best_bcd=0x00120, next move settles at 0x00108 → last_bcd=0x00108, best_bcd=0x00120 unchanged, score_valid pulses once.
- Abort: new_game during WAIT → no score_valid, scorer_rst low 6 cycles, last_bcd=0, new_best=0, best_bcd preserved.
- Collision: new_game and move_valid with mask 0x8000 in the same IDLE cycle → no score_en ever issued and the state enters CLEAR; then rst low → best_bcd=0.
